player_state_tx: RTL and testbench

Serial transmitter that sends the local player's game state (level, x, y) to the opponent's board over a single UART line. The opponent's board decodes these values into its level_rm / x_value_rm / y_value_rm inputs for race and finish detection. The block sits beside the drawing pipeline in the 65 MHz VGA clock domain. A send is triggered once per frame by an external request pulse.

---
 rtl/player_state_tx.sv | 145 ++++++++++++++
 tb/tb_player_state_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/player_state_tx.sv
// 8N1 UART transmitter for the local player's state frame:
// SYNC, {00,level,x[11:8]}, x[7:0], {0000,y[11:8]}, y[7:0], XOR checksum.
module player_state_tx #(
    parameter int          CLK_HZ       = 65_000_000,
    parameter int          BAUD         = 115_200,
    parameter int          CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [1:0]  level,
    input  logic [11:0] x_value,
    input  logic [11:0] y_value,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic        req_dropped
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  baud_cnt, baud_cnt_d;
    logic [2:0]     bit_idx, bit_idx_d;
    logic [2:0]     byte_idx, byte_idx_d;
    logic           load;
    logic           tx_d, done_d;

    logic [1:0]     snap_level;
    logic [11:0]    snap_x, snap_y;
    logic [7:0]     b1, b2, b3, b4, chk, cur_byte;

    assign b1  = {2'b00, snap_level, snap_x[11:8]};
    assign b2  = snap_x[7:0];
    assign b3  = {4'b0000, snap_y[11:8]};
    assign b4  = snap_y[7:0];
    assign chk = b1 ^ b2 ^ b3 ^ b4;

    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
            3'd4:    cur_byte = b4;
            default: cur_byte = chk;
        endcase
    end

    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt + CW'(1);
        bit_idx_d  = bit_idx;
        byte_idx_d = byte_idx;
        load       = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_d = '0;
                if (send_req) begin
                    load       = 1'b1;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (byte_idx < 3'd5) begin
                        byte_idx_d = byte_idx + 3'd1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered, so it is derived from the state being entered
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            state       <= state_d;
            baud_cnt    <= baud_cnt_d;
            bit_idx     <= bit_idx_d;
            byte_idx    <= byte_idx_d;
            tx          <= tx_d;
            busy        <= (state_d != IDLE);
            frame_done  <= done_d;
            req_dropped <= send_req && (state != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_level <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
        end else if (load) begin
            snap_level <= level;
            snap_x     <= x_value;
            snap_y     <= y_value;
        end
    end

endmodule

// File: tb/tb_player_state_tx.sv
// Bench for player_state_tx: directed scenarios plus random traffic checked
// every cycle against a slot-timing model of the serial frame.
module tb_player_state_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 60 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_req = 1'b0;
    logic [1:0]  lvl = '0;
    logic [11:0] xv = '0;
    logic [11:0] yv = '0;
    logic        tx, busy, frame_done, req_dropped;

    int n_total = 0;
    int n_pass  = 0;

    player_state_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .send_req(send_req),
        .level(lvl), .x_value(xv), .y_value(yv),
        .tx(tx), .busy(busy), .frame_done(frame_done), .req_dropped(req_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [47:0] model_bytes(input logic [1:0] l, input logic [11:0] x,
                                                input logic [11:0] y);
        logic [7:0] c1, c2, c3, c4;
        c1 = {2'b00, l, x[11:8]};
        c2 = x[7:0];
        c3 = {4'h0, y[11:8]};
        c4 = y[7:0];
        return {8'hA5, c1, c2, c3, c4, c1 ^ c2 ^ c3 ^ c4};
    endfunction

    // Model: elapsed cycles t since acceptance select a 10-slot byte frame.
    logic        m_valid = 1'b0;
    logic        m_active = 1'b0;
    int          m_t = 0;
    logic [47:0] m_bytes = '0;
    logic        e_done = 1'b0;
    logic        e_drop = 1'b0;

    function automatic logic model_tx(input int t, input logic [47:0] fb);
        int k, b, p;
        logic [7:0] byt;
        k = t / CPB;
        b = k / 10;
        p = k % 10;
        byt = fb[47 - 8*b -: 8];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return byt[p-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            e_done   = 1'b0;
            e_drop   = 1'b0;
        end else begin
            e_drop = send_req && m_active;
            e_done = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) begin
                    m_active = 1'b0;
                    e_done   = 1'b1;
                end
            end else if (send_req) begin
                m_active = 1'b1;
                m_t      = 0;
                m_bytes  = model_bytes(lvl, xv, yv);
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",          {47'd0, tx},          {47'd0, m_active ? model_tx(m_t, m_bytes) : 1'b1});
            chk("busy",        {47'd0, busy},        {47'd0, m_active});
            chk("frame_done",  {47'd0, frame_done},  {47'd0, e_done});
            chk("req_dropped", {47'd0, req_dropped}, {47'd0, e_drop});
        end
    end

    // Raw capture of the line for decoding against literal byte values
    logic txq[$];
    int   done_cnt = 0;
    int   drop_cnt = 0;
    always @(negedge clk) begin
        if (busy) txq.push_back(tx);
        if (frame_done) done_cnt++;
        if (req_dropped) drop_cnt++;
    end

    task automatic check_capture(input string tag, input logic [47:0] exp);
        logic [7:0] got;
        chk({tag, "_busy_len"}, 48'(txq.size()), 48'(FRAME));
        if (txq.size() >= FRAME) begin
            for (int b = 0; b < 6; b++) begin
                chk({tag, "_start"}, {47'd0, txq[(b*10)*CPB + CPB/2]}, 48'd0);
                for (int i = 0; i < 8; i++) got[i] = txq[(b*10 + 1 + i)*CPB + CPB/2];
                chk({tag, "_byte"}, {40'd0, got}, {40'd0, exp[47 - 8*b -: 8]});
                chk({tag, "_stop"}, {47'd0, txq[(b*10 + 9)*CPB + CPB/2]}, 48'd1);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        #1;
        chk({tag, "_done_seen"}, {47'd0, n < 1000}, 48'd1);
    endtask

    task automatic send(input logic [1:0] l, input logic [11:0] x, input logic [11:0] y);
        lvl = l; xv = x; yv = y;
        send_req = 1'b1;
        @(posedge clk); #1;
        send_req = 1'b0;
    endtask

    initial begin
        chk("model_pin_a", model_bytes(2'b11, 12'h258, 12'h069), 48'hA5_32_58_00_69_03);
        chk("model_pin_b", model_bytes(2'b00, 12'h000, 12'h000), 48'hA5_00_00_00_00_00);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx",   {47'd0, tx},   48'd1);
        chk("reset_busy", {47'd0, busy}, 48'd0);
        repeat (1000) @(negedge clk);
        chk("idle_no_busy", 48'(txq.size()), 48'd0);

        // Single frame with snapshot: inputs change one cycle after the request
        #1; txq.delete(); done_cnt = 0;
        send(2'b11, 12'h258, 12'h069);
        xv = 12'hFFF; yv = 12'h000;
        wait_done("single");
        check_capture("single", 48'hA5_32_58_00_69_03);
        chk("single_done_cnt", 48'(done_cnt), 48'd1);

        // Drop: request 50 cycles into a frame
        repeat (20) @(posedge clk);
        #1; txq.delete(); done_cnt = 0; drop_cnt = 0;
        send(2'b01, 12'hABC, 12'h123);
        repeat (49) @(posedge clk);
        #1 send_req = 1'b1; lvl = 2'b10; xv = 12'h111; yv = 12'h222;
        @(posedge clk); #1 send_req = 1'b0;
        wait_done("drop");
        check_capture("drop", model_bytes(2'b01, 12'hABC, 12'h123));
        repeat (300) @(negedge clk);
        chk("drop_done_cnt", 48'(done_cnt), 48'd1);
        chk("drop_pulse_cnt", 48'(drop_cnt), 48'd1);

        // Back-to-back: request in the frame_done cycle
        #1; txq.delete();
        send(2'b10, 12'h7E1, 12'h5A5);
        wait_done("b2b_first");
        check_capture("b2b_first", model_bytes(2'b10, 12'h7E1, 12'h5A5));
        txq.delete();
        send(2'b00, 12'h000, 12'h000);
        @(negedge clk);
        chk("b2b_start_tx",   {47'd0, tx},   48'd0);
        chk("b2b_start_busy", {47'd0, busy}, 48'd1);
        wait_done("b2b_second");
        check_capture("b2b_second", 48'hA5_00_00_00_00_00);

        // Reset during byte 3
        repeat (10) @(posedge clk);
        #1; done_cnt = 0;
        send(2'b11, 12'h258, 12'h069);
        repeat (90) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx",   {47'd0, tx},   48'd1);
        chk("midrst_busy", {47'd0, busy}, 48'd0);
        repeat (300) @(negedge clk);
        chk("midrst_no_done", 48'(done_cnt), 48'd0);
        #1; txq.delete();
        send(2'b11, 12'h258, 12'h069);
        wait_done("after_rst");
        check_capture("after_rst", 48'hA5_32_58_00_69_03);

        // Random traffic, including inputs changing every cycle and rare resets
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk); #1;
            send_req = ($urandom_range(0, 99) < 3);
            rst      = ($urandom_range(0, 1999) == 0);
            lvl      = 2'($urandom);
            xv       = 12'($urandom);
            yv       = 12'($urandom);
        end
        @(posedge clk); #1;
        send_req = 1'b0; rst = 1'b0;
        repeat (300) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
